// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU controller: default widths and FSM states.
package uart_alu_pkg;

  localparam int unsigned DEFAULT_BITS_DATA = 8;
  localparam int unsigned DEFAULT_BITS_OP   = 6;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  // States in which received bytes are refused.
  function automatic logic is_busy(state_t s);
    return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte timeout counter in s_tick units; expired is a combinational strobe on the final tick.
module rx_timeout #(
  parameter logic [15:0] TICKS = 16'd40000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  logic [15:0] count;

  assign expired = enable && tick && (count == TICKS - 16'd1);

  // Clear wins over counting so an accepted byte always restarts the window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable && tick) begin
      count <= expired ? 16'd0 : count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from the UART receiver, lets the ALU settle, then sends the result.
// Optional inter-byte timeout is enabled with `define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned BITS_DATA     = DEFAULT_BITS_DATA,
  parameter int unsigned BITS_OP       = DEFAULT_BITS_OP,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd40000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_s_tick,
  input  logic                 i_rx_done,
  input  logic [BITS_DATA-1:0] i_rx_data,
  input  logic [BITS_DATA-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic [BITS_DATA-1:0] o_alu_a,
  output logic [BITS_DATA-1:0] o_alu_b,
  output logic [BITS_OP-1:0]   o_alu_op,
  output logic                 o_tx_start,
  output logic [BITS_DATA-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic                 o_timeout
);

  state_t state, state_next;
  logic   load_a_c, load_b_c, load_op_c, load_tx_c;
  logic   accept_c, overrun_c, expired_c;

  always_comb begin
    state_next = state;
    load_a_c   = 1'b0;
    load_b_c   = 1'b0;
    load_op_c  = 1'b0;
    load_tx_c  = 1'b0;
    accept_c   = i_rx_done && !is_busy(state);
    overrun_c  = i_rx_done && is_busy(state);
    case (state)
      WAIT_A: begin
        if (i_rx_done) begin
          load_a_c   = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          load_b_c   = 1'b1;
          state_next = WAIT_OP;
        end else if (expired_c) begin
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          load_op_c  = 1'b1;
          state_next = EXEC;
        end else if (expired_c) begin
          state_next = WAIT_A;
        end
      end
      // Operands are stable throughout EXEC, so the ALU result is captured at its end.
      EXEC: begin
        load_tx_c  = 1'b1;
        state_next = SEND;
      end
      SEND: state_next = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_next;
  end

  // tx_start and tx_data become valid together for the single SEND cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (load_a_c)  o_alu_a   <= i_rx_data;
      if (load_b_c)  o_alu_b   <= i_rx_data;
      if (load_op_c) o_alu_op  <= i_rx_data[BITS_OP-1:0];
      if (load_tx_c) o_tx_data <= i_alu_result;
      if (overrun_c) o_overrun <= 1'b1;
      o_tx_start <= load_tx_c;
      o_busy     <= is_busy(state_next);
    end
  end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic counting_c;
  assign counting_c = (state == WAIT_B) || (state == WAIT_OP);

  rx_timeout #(
    .TICKS(TIMEOUT_TICKS)
  ) u_rx_timeout (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (accept_c),
    .enable (counting_c),
    .tick   (i_s_tick),
    .expired(expired_c)
  );

  // A byte arriving on the expiry tick takes precedence and suppresses the report.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_timeout <= 1'b0;
    else         o_timeout <= expired_c && !i_rx_done;
  end
`else
  logic unused_timeout_c;
  assign expired_c        = 1'b0;
  assign o_timeout        = 1'b0;
  assign unused_timeout_c = ^{i_s_tick, TIMEOUT_TICKS, accept_c};
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed self-checking bench for uart_alu_ctrl (timeout cases follow UART_ALU_CTRL_TIMEOUT_EN).
module tb_uart_alu_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_s_tick = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic [7:0] i_alu_result = 8'h00;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_overrun, o_timeout;

  int n_cmp = 0;
  int n_err = 0;

  uart_alu_ctrl #(
    .BITS_DATA    (8),
    .BITS_OP      (6),
    .TIMEOUT_TICKS(16'd4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_s_tick    (i_s_tick),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .i_alu_result(i_alu_result),
    .i_tx_done   (i_tx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    cyc();
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    cyc();
    i_tx_done = 1'b0;
  endtask

  task automatic s_tick_gap();
    i_s_tick = 1'b1;
    cyc();
    i_s_tick = 1'b0;
    cyc();
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    i_reset = 1'b0;
    chk("rst_a", 32'(o_alu_a), 32'h00);
    chk("rst_b", 32'(o_alu_b), 32'h00);
    chk("rst_op", 32'(o_alu_op), 32'h00);
    chk("rst_txd", 32'(o_tx_data), 32'h00);
    chk("rst_txs", 32'(o_tx_start), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_ovr", 32'(o_overrun), 32'h0);
    chk("rst_to", 32'(o_timeout), 32'h0);

    // basic transaction: 05, 03, 20 -> result 08
    i_alu_result = 8'h08;
    send_byte(8'h05);
    chk("s1_a", 32'(o_alu_a), 32'h05);
    chk("s1_busy_b", 32'(o_busy), 32'h0);
    send_byte(8'h03);
    chk("s1_b", 32'(o_alu_b), 32'h03);
    send_byte(8'h20);
    chk("s1_op", 32'(o_alu_op), 32'h20);
    chk("s1_busy_exec", 32'(o_busy), 32'h1);
    chk("s1_txs_exec", 32'(o_tx_start), 32'h0);
    cyc();
    chk("s1_txs_send", 32'(o_tx_start), 32'h1);
    chk("s1_txd", 32'(o_tx_data), 32'h08);
    cyc();
    chk("s1_txs_wait", 32'(o_tx_start), 32'h0);
    chk("s1_busy_wait", 32'(o_busy), 32'h1);
    pulse_tx_done();
    chk("s1_busy_done", 32'(o_busy), 32'h0);
    chk("s1_ovr", 32'(o_overrun), 32'h0);

    // overrun during WAIT_TX
    i_alu_result = 8'h3C;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h2A);
    cyc();
    chk("s2_txd", 32'(o_tx_data), 32'h3C);
    cyc();
    send_byte(8'h7F);
    chk("s2_ovr", 32'(o_overrun), 32'h1);
    chk("s2_a_hold", 32'(o_alu_a), 32'h11);
    chk("s2_b_hold", 32'(o_alu_b), 32'h22);
    chk("s2_op_hold", 32'(o_alu_op), 32'h2A);
    chk("s2_busy", 32'(o_busy), 32'h1);
    pulse_tx_done();
    pulse_tx_done();
    send_byte(8'h33);
    chk("s2_a_next", 32'(o_alu_a), 32'h33);
    chk("s2_b_kept", 32'(o_alu_b), 32'h22);
    chk("s2_ovr_sticky", 32'(o_overrun), 32'h1);

    // tx_done in WAIT_B ignored; opcode E2 truncates to 22
    pulse_tx_done();
    send_byte(8'h44);
    chk("s3_b", 32'(o_alu_b), 32'h44);
    i_alu_result = 8'h5B;
    send_byte(8'hE2);
    chk("s3_op_trunc", 32'(o_alu_op), 32'h22);
    cyc();
    chk("s3_txs", 32'(o_tx_start), 32'h1);
    chk("s3_txd", 32'(o_tx_data), 32'h5B);
    cyc();

    // reset while in WAIT_TX
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    chk("r_a", 32'(o_alu_a), 32'h00);
    chk("r_b", 32'(o_alu_b), 32'h00);
    chk("r_op", 32'(o_alu_op), 32'h00);
    chk("r_txd", 32'(o_tx_data), 32'h00);
    chk("r_busy", 32'(o_busy), 32'h0);
    chk("r_ovr", 32'(o_overrun), 32'h0);
    pulse_tx_done();
    for (int i = 0; i < 5; i++) begin
      chk("r_no_txs", 32'(o_tx_start), 32'h0);
      cyc();
    end
    send_byte(8'h09);
    chk("r_a_after", 32'(o_alu_a), 32'h09);
    chk("r_busy_after", 32'(o_busy), 32'h0);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // timeout after four ticks in WAIT_B
    s_tick_gap(); s_tick_gap(); s_tick_gap();
    chk("to_pre", 32'(o_timeout), 32'h0);
    i_s_tick = 1'b1;
    cyc();
    i_s_tick = 1'b0;
    chk("to_pulse", 32'(o_timeout), 32'h1);
    chk("to_busy", 32'(o_busy), 32'h0);
    cyc();
    chk("to_pulse_end", 32'(o_timeout), 32'h0);
    send_byte(8'h66);
    chk("to_a_reload", 32'(o_alu_a), 32'h66);
    chk("to_b_kept", 32'(o_alu_b), 32'h00);

    // byte coincident with the expiring tick wins
    s_tick_gap(); s_tick_gap(); s_tick_gap();
    i_s_tick  = 1'b1;
    i_rx_data = 8'h77;
    i_rx_done = 1'b1;
    cyc();
    i_s_tick  = 1'b0;
    i_rx_done = 1'b0;
    chk("co_b", 32'(o_alu_b), 32'h77);
    chk("co_to", 32'(o_timeout), 32'h0);
    cyc();
    chk("co_to_next", 32'(o_timeout), 32'h0);
    s_tick_gap(); s_tick_gap(); s_tick_gap();
    chk("co_to_restart", 32'(o_timeout), 32'h0);
    send_byte(8'h01);
    chk("co_op", 32'(o_alu_op), 32'h01);
    chk("co_busy", 32'(o_busy), 32'h1);
`else
    // no timeout: ticks never abandon WAIT_B
    for (int i = 0; i < 10; i++) s_tick_gap();
    chk("nt_to", 32'(o_timeout), 32'h0);
    send_byte(8'h66);
    chk("nt_b", 32'(o_alu_b), 32'h66);
    chk("nt_a_kept", 32'(o_alu_a), 32'h09);
    chk("nt_busy_b", 32'(o_busy), 32'h0);
    send_byte(8'h01);
    chk("nt_op", 32'(o_alu_op), 32'h01);
    chk("nt_busy", 32'(o_busy), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter BITS_DATA, default 8, is the width of the UART byte, the ALU operands and the ALU result.
REQ-002 Parameter BITS_OP, default 6, is the ALU opcode width and SHALL be at most BITS_DATA.
REQ-003 Parameter TIMEOUT_TICKS, default 16'd40000, is the inter-byte timeout in s_tick units and is used only with the timeout feature.
REQ-004 Clock i_clk, input, 1 bit: all state changes on the rising edge.
REQ-005 Reset i_reset, input, 1 bit: synchronous, active-high.
REQ-006 i_s_tick, input, 1 bit: baud oversampling tick, shared with the UART receiver.
REQ-007 i_rx_done, input, 1 bit: one-cycle pulse from the receiver meaning a byte is valid.
REQ-008 i_rx_data, input, BITS_DATA bits: received byte, sampled only on i_rx_done.
REQ-009 i_alu_result, input, BITS_DATA bits: combinational ALU output.
REQ-010 i_tx_done, input, 1 bit: one-cycle pulse from the transmitter meaning the frame is finished.
REQ-011 o_alu_a, output, BITS_DATA bits: registered operand A.
REQ-012 o_alu_b, output, BITS_DATA bits: registered operand B.
REQ-013 o_alu_op, output, BITS_OP bits: registered opcode.
REQ-014 o_tx_start, output, 1 bit: one-cycle pulse requesting transmission.
REQ-015 o_tx_data, output, BITS_DATA bits: registered byte to transmit.
REQ-016 o_busy, output, 1 bit: high in the EXEC, SEND and WAIT_TX states.
REQ-017 o_overrun, output, 1 bit: sticky flag.
REQ-018 o_timeout, output, 1 bit: one-cycle pulse.

Function
REQ-019 The FSM SHALL have exactly these states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-020 WAIT_A: on i_rx_done, o_alu_a <= i_rx_data and the state SHALL move to WAIT_B.
REQ-021 WAIT_B: on i_rx_done, o_alu_b <= i_rx_data and the state SHALL move to WAIT_OP.
REQ-022 WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[BITS_OP-1:0] (upper bits discarded) and the state SHALL move to EXEC.
REQ-023 EXEC SHALL last exactly one cycle, which is the ALU settle cycle, and SHALL then move to SEND.
REQ-024 SEND: o_tx_data <= i_alu_result and o_tx_start SHALL be high for exactly this one cycle; the state SHALL then move to WAIT_TX.
REQ-025 WAIT_TX: on i_tx_done the state SHALL move to WAIT_A.
REQ-026 Latency: o_tx_start SHALL assert exactly 2 cycles after the i_rx_done that carries the opcode.
REQ-027 Operand and opcode registers SHALL hold their values until overwritten by a new byte.
REQ-028 An i_rx_done while o_busy is high SHALL be ignored and SHALL set o_overrun.
REQ-029 o_overrun SHALL be cleared only by reset.
REQ-030 An i_tx_done outside WAIT_TX SHALL be ignored.
REQ-031 i_s_tick SHALL affect only the timeout counter.

Reset
REQ-032 On reset: state = WAIT_A; o_alu_a, o_alu_b, o_alu_op and o_tx_data = 0; o_tx_start, o_overrun and o_timeout = 0; timeout counter = 0.
REQ-033 Reset asserted mid-operation, including during WAIT_TX, SHALL abandon the transaction with no o_tx_start afterwards.

Configuration
REQ-034 With UART_ALU_CTRL_TIMEOUT_EN defined, a counter SHALL clear on every accepted i_rx_done and increment on each i_s_tick while in WAIT_B or WAIT_OP.
REQ-035 With UART_ALU_CTRL_TIMEOUT_EN defined, when the counter reaches TIMEOUT_TICKS-1 on an i_s_tick, the state SHALL return to WAIT_A, o_timeout SHALL pulse for one cycle, and the registers SHALL remain unchanged.
REQ-036 If i_rx_done and timeout expiry occur in the same cycle, the byte SHALL win and no timeout SHALL be reported.
REQ-037 Without UART_ALU_CTRL_TIMEOUT_EN, no counter SHALL exist, o_timeout SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Structure
REQ-038 The package uart_alu_pkg SHALL hold the state localparams and the default widths BITS_DATA and BITS_OP.
REQ-039 The timeout counter SHALL be the sub-module rx_timeout (inputs clk, reset, clear, enable, tick; output expired), instantiated only under the macro.

Verification
REQ-040 Scenario: bytes 0x05, 0x03, 0x20 then ALU result 0x08 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_start one pulse 2 cycles after the third i_rx_done, o_tx_data=0x08.
REQ-041 Scenario: opcode byte 0xE2 -> o_alu_op=0x22.
REQ-042 Scenario: i_rx_done with 0x7F during WAIT_TX -> o_overrun=1, operands unchanged; after i_tx_done the next byte is accepted as A.
REQ-043 Scenario: reset asserted in WAIT_TX -> all outputs 0, state WAIT_A, no o_tx_start after i_tx_done.
REQ-044 Scenario (macro on, TIMEOUT_TICKS=4): byte A, then 4 s_ticks -> o_timeout pulse, state WAIT_A; the next byte loads o_alu_a.
REQ-045 Scenario: i_rx_done coincident with the 4th s_tick -> byte accepted, no o_timeout.
